// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive peripheral: receiver FSM states,
// register addresses, status bit positions and the default bit period.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

   localparam logic ADDR_DATA   = 1'b0;
   localparam logic ADDR_STATUS = 1'b1;

   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FRAME_ERR = 3;

   // 100 MHz system clock at 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO for received characters. A pop on an empty
// FIFO is ignored; a push on a full FIFO only lands if a pop frees a slot
// in the same cycle, so count is unchanged in that case.
module uart_rx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pop_eff;
   logic          push_eff;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign pop_eff  = pop && !empty;
   assign push_eff = push && (!full || pop_eff);
   assign head     = mem[rd_ptr];

   // Storage array; written only when a push is accepted, no reset needed
   always_ff @(posedge clk) begin
      if (push_eff) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_eff) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_eff) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_eff, pop_eff})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver. The serial line is synchronised, framed
// by a mid-bit sampling FSM, and completed bytes are queued in a FIFO that
// the core drains through the DATA register. STATUS exposes FIFO state and
// sticky error flags, which a STATUS read clears.
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_i,
   input  logic        rd_en,
   input  logic        addr,
   output logic [31:0] rdata,
   output logic        rx_irq
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic             sync1;
   logic             rx_s;
   logic             rx_prev;
   rx_state_e        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             push_pulse;
   logic             ferr_pulse;
   logic             frame_err;
   logic             overrun;
   logic [7:0]       head;
   logic             full;
   logic             empty;
   logic             rd_data;
   logic             rd_status;

   assign rd_data   = rd_en && (addr == ADDR_DATA);
   assign rd_status = rd_en && (addr == ADDR_STATUS);

   // Two-flop synchroniser plus one extra stage to detect the start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx_i;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   // Frame FSM: half-bit wait to centre on the start bit, then one full bit
   // period per sample; push/error pulses are registered for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         push_pulse <= 1'b0;
         ferr_pulse <= 1'b0;
      end else begin
         push_pulse <= 1'b0;
         ferr_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  state <= START;
                  cnt   <= HALF_LOAD;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                     cnt     <= FULL_LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shift[bit_idx] <= rx_s;
                  cnt            <= FULL_LOAD;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt == '0) begin
                  push_pulse <= rx_s;
                  ferr_pulse <= !rx_s;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   uart_rx_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_pulse),
      .push_data(shift),
      .pop      (rd_data),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   // Sticky error flags: a STATUS read clears them, a new event in the same
   // cycle wins; a push into a full FIFO is an overrun unless a pop frees room
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_pulse || (frame_err && !rd_status);
         overrun   <= (push_pulse && full && !rd_data) || (overrun && !rd_status);
      end
   end

   // Read mux follows addr every cycle; side effects only happen on rd_en
   always_comb begin
      rdata = '0;
      if (addr == ADDR_DATA) begin
         if (!empty) begin
            rdata[7:0] = head;
         end
      end else begin
         rdata[ST_NOT_EMPTY] = !empty;
         rdata[ST_FULL]      = full;
         rdata[ST_OVERRUN]   = overrun;
         rdata[ST_FRAME_ERR] = frame_err;
      end
   end

   assign rx_irq = !empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio. Frames are driven bit by bit on
// rx_i and a queue-based model of the receiver's visible behaviour predicts
// every register read.
module tb_uart_rx_mmio;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        rx_i;
   logic        rd_en;
   logic        addr;
   logic [31:0] rdata;
   logic        rx_irq;

   int compared;
   int mismatched;

   logic [7:0] model_q[$];
   logic       model_ferr;
   logic       model_ovr;

   uart_rx_mmio #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .rx_i  (rx_i),
      .rd_en (rd_en),
      .addr  (addr),
      .rdata (rdata),
      .rx_irq(rx_irq)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Model: a complete frame either queues a byte, overruns, or flags a framing error
   function automatic void modelFrame(input logic [7:0] b, input logic stop_ok);
      if (!stop_ok) begin
         model_ferr = 1'b1;
      end else if (model_q.size() == DEPTH) begin
         model_ovr = 1'b1;
      end else begin
         model_q.push_back(b);
      end
   endfunction

   function automatic logic [31:0] modelPeek(input logic a);
      logic [31:0] r;
      r = 32'd0;
      if (a == 1'b0) begin
         if (model_q.size() != 0) r = {24'd0, model_q[0]};
      end else begin
         r = {28'd0, model_ferr, model_ovr, model_q.size() == DEPTH, model_q.size() != 0};
      end
      return r;
   endfunction

   function automatic logic [31:0] modelRead(input logic a);
      logic [31:0] r;
      r = modelPeek(a);
      if (a == 1'b0) begin
         if (model_q.size() != 0) void'(model_q.pop_front());
      end else begin
         model_ferr = 1'b0;
         model_ovr  = 1'b0;
      end
      return r;
   endfunction

   function automatic void modelReset();
      model_q.delete();
      model_ferr = 1'b0;
      model_ovr  = 1'b0;
   endfunction

   // Drive one 8N1 frame aligned to a falling clock edge, then idle high
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_i = stop_bit;
      repeat (CPB) @(negedge clk);
      rx_i = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   // One load access: rdata captured in the strobe cycle
   task automatic readReg(input logic a, output logic [31:0] d);
      @(negedge clk);
      addr  = a;
      rd_en = 1'b1;
      #1 d = rdata;
      @(posedge clk);
      #1 rd_en = 1'b0;
   endtask

   task automatic doRead(input logic a, input string tag);
      logic [31:0] d;
      logic [31:0] e;
      readReg(a, d);
      e = modelRead(a);
      checkOutput(tag, d, e);
      checkOutput({tag, "_irq"}, 32'(rx_irq), 32'(model_q.size() != 0));
   endtask

   task automatic doPeek(input logic a, input string tag);
      @(negedge clk);
      addr = a;
      #1 checkOutput(tag, rdata, modelPeek(a));
   endtask

   initial begin
      int          lat;
      int          k;
      logic [31:0] sim_d;
      logic [31:0] sim_e;
      logic [7:0]  rb;
      logic        rs;

      compared   = 0;
      mismatched = 0;
      lat        = 80;
      rst        = 1'b1;
      rx_i       = 1'b1;
      rd_en      = 1'b0;
      addr       = 1'b0;
      modelReset();

      // Reset state
      repeat (3) @(negedge clk);
      #1 checkOutput("rst_data", rdata, 32'd0);
      checkOutput("rst_irq", 32'(rx_irq), 32'd0);
      addr = 1'b1;
      #1 checkOutput("rst_status", rdata, 32'd0);
      addr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single byte, measuring start-edge to interrupt latency
      fork
         applyStimulus(8'hA5, 1'b1);
         begin
            @(negedge clk);
            k = 0;
            while (!rx_irq && k < 300) begin
               @(negedge clk);
               k++;
            end
            if (rx_irq) lat = k;
         end
      join
      checkOutput("a5_irq_rise", 32'(rx_irq), 32'd1);
      modelFrame(8'hA5, 1'b1);
      doPeek(1'b1, "a5_peek_status");
      doPeek(1'b0, "a5_peek_data");
      doRead(1'b1, "a5_status");
      doRead(1'b0, "a5_data");
      doRead(1'b1, "a5_status_after");

      // Overrun on the fifth byte
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(8'(i), 1'b1);
         modelFrame(8'(i), 1'b1);
      end
      doRead(1'b1, "ovr_status");
      doRead(1'b1, "ovr_status2");
      for (int i = 0; i < 5; i++) doRead(1'b0, "ovr_data");

      // Framing error then a good frame
      applyStimulus(8'h3C, 1'b0);
      modelFrame(8'h3C, 1'b0);
      doRead(1'b1, "ferr_status");
      doRead(1'b1, "ferr_status2");
      applyStimulus(8'h55, 1'b1);
      modelFrame(8'h55, 1'b1);
      doRead(1'b0, "ferr_next_data");

      // Short low glitch must not start a frame
      @(negedge clk);
      rx_i = 1'b0;
      repeat (2) @(negedge clk);
      rx_i = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      doRead(1'b1, "glitch_status");
      doRead(1'b0, "glitch_data");

      // Reset in the middle of data bit 4 while a byte is pending
      applyStimulus(8'h11, 1'b1);
      modelFrame(8'h11, 1'b1);
      rb = 8'hF5;
      @(negedge clk);
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_i = rb[i];
         repeat (CPB) @(negedge clk);
      end
      rx_i = rb[4];
      repeat (3) @(negedge clk);
      rst  = 1'b1;
      addr = 1'b0;
      modelReset();
      #1 checkOutput("midrst_data", rdata, 32'd0);
      checkOutput("midrst_irq", 32'(rx_irq), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (CPB - 4) @(negedge clk);
      for (int i = 5; i < 8; i++) begin
         rx_i = rb[i];
         repeat (CPB) @(negedge clk);
      end
      rx_i = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      doRead(1'b1, "midrst_status");
      doRead(1'b0, "midrst_nobyte");
      applyStimulus(8'hC3, 1'b1);
      modelFrame(8'hC3, 1'b1);
      doRead(1'b0, "midrst_c3");

      // Full FIFO: frame completes in the same cycle as a DATA pop
      for (int i = 0; i < DEPTH; i++) begin
         rb = 8'($urandom_range(0, 255));
         applyStimulus(rb, 1'b1);
         modelFrame(rb, 1'b1);
      end
      sim_d = 32'd0;
      fork
         applyStimulus(8'h99, 1'b1);
         begin
            @(negedge clk);
            repeat (lat - 1) @(negedge clk);
            addr  = 1'b0;
            rd_en = 1'b1;
            #1 sim_d = rdata;
            @(posedge clk);
            #1 rd_en = 1'b0;
         end
      join
      sim_e = modelRead(1'b0);
      modelFrame(8'h99, 1'b1);
      checkOutput("simul_pop", sim_d, sim_e);
      doRead(1'b1, "simul_status");
      for (int i = 0; i <= DEPTH; i++) doRead(1'b0, "simul_drain");

      // Randomised frames and reads
      for (int n = 0; n < 14; n++) begin
         rb = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 5) != 0);
         applyStimulus(rb, rs);
         modelFrame(rb, rs);
         k = $urandom_range(0, 2);
         for (int r = 0; r < k; r++) begin
            doRead(1'($urandom_range(0, 1)), "rand_read");
         end
      end
      doRead(1'b1, "rand_final_status");
      for (int i = 0; i <= DEPTH; i++) doRead(1'b0, "rand_final_data");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
